avl_uart_arbiter: RTL
=====================

// Module: avl_uart_arbiter
// PURPOSE
//  Shares the single Avalon-MM slave port of the UART interface between NB_MASTERS
//  Avalon-MM masters (e.g. CPU and DMA). Round-robin, one transaction in flight;
//  a read holds the slave until its readdatavalid returns. Sits between the bus
//  masters and avl_uart_interface, same clock domain.
// PARAMETERS
//  NB_MASTERS  2   number of requesting masters (2..8)
//  TIMEOUT     64  max cycles waiting for s_readdatavalid_i (AVL_UART_ARB_TIMEOUT_EN only)
// PORTS
//  avl_clk_i          in   1               clock
//  avl_reset_n_i      in   1               reset, asynchronous, active-low
//  m_address_i        in   [NB_MASTERS][14] per-master address
//  m_byteenable_i     in   [NB_MASTERS][4]  per-master byteenable
//  m_writedata_i      in   [NB_MASTERS][32] per-master write data
//  m_write_i          in   [NB_MASTERS]     per-master write request
//  m_read_i           in   [NB_MASTERS]     per-master read request
//  m_waitrequest_o    out  [NB_MASTERS]     per-master waitrequest
//  m_readdatavalid_o  out  [NB_MASTERS]     per-master readdatavalid
//  m_readdata_o       out  32              read data, broadcast to all masters
//  s_address_o        out  14              to UART
//  s_byteenable_o     out  4               to UART
//  s_writedata_o      out  32              to UART
//  s_write_o/s_read_o out  1 each          to UART
//  s_readdata_i       in   32              from UART
//  s_waitrequest_i    in   1               from UART
//  s_readdatavalid_i  in   1               from UART
//  err_timeout_o      out  1               one-cycle pulse on read timeout
// BEHAVIOUR
//  Reset: state IDLE, m_waitrequest_o all 1, m_readdatavalid_o 0, m_readdata_o 0,
//   s_read_o/s_write_o 0, s_* data/addr 0, err_timeout_o 0, last_grant=NB_MASTERS-1.
//  FSM IDLE -> ISSUE -> (WAIT_RDV) -> IDLE:
//  - IDLE: all waitrequest 1, s_read/s_write 0. If any m_read|m_write: pick first
//    requester scanning last_grant+1 upward (mod NB_MASTERS), register grant, go ISSUE.
//    Arbitration latency 1 cycle.
//  - ISSUE: s_* driven combinationally from master[grant]; m_waitrequest_o[grant] =
//    s_waitrequest_i, others 1. On s_waitrequest_i=0: write -> IDLE; read -> WAIT_RDV;
//    last_grant<=grant in both cases.
//  - WAIT_RDV: s_read/s_write 0, all waitrequest 1. On s_readdatavalid_i:
//    m_readdatavalid_o[grant]=1 same cycle, m_readdata_o=s_readdata_i, -> IDLE.
//  - Min cost: write 2 cycles, read 3 cycles + UART read latency.
//  - m_read_i and m_write_i both high on one master: treated as read (assertion flags it).
//  - Master dropping request while in ISSUE: Avalon violation, unsupported, asserted.
//  - s_readdatavalid_i outside WAIT_RDV: ignored, never forwarded.
//  - Reset mid-operation: immediate return to IDLE; late rdv of aborted read dropped.
//  - Only one master ever sees waitrequest=0 or readdatavalid=1 in a cycle.
// CONFIGURATION
//  AVL_UART_ARB_TIMEOUT_EN defined: counter runs in WAIT_RDV; after TIMEOUT cycles
//   without rdv, m_readdatavalid_o[grant]=1 with m_readdata_o=32'hDEADBEEF,
//   err_timeout_o pulses 1 cycle, -> IDLE; subsequent stray rdv ignored.
//  Not defined: WAIT_RDV waits indefinitely, no counter, err_timeout_o tied 0.
// STRUCTURE
//  Package avl_uart_arb_pkg: arb_state_t enum {IDLE,ISSUE,WAIT_RDV},
//   TIMEOUT_DATA=32'hDEADBEEF, grant index width function.
//  Sub-module avl_uart_rr_picker: combinational round-robin pick
//   (req vector, last_grant -> grant index, valid).
// TESTING
//  1 Reset held 5 cycles, released -> waitrequest all 1, s_read/s_write 0, err 0.
//  2 m0 write addr 1 data 0x55, s_waitrequest_i=0 -> s_write_o 1 cycle, addr 1,
//    data 0x55, m_waitrequest_o[0]=0 same cycle, 2 cycles total.
//  3 m0,m1 continuous reads, UART rdv latency 2 -> grants 0,1,0,1; each master
//    receives only its own readdatavalid/data.
//  4 m0 read with rdv delayed 5 cycles while m1 write pending -> s_write_o for m1
//    only after m0 rdv; m1 waitrequest stays 1 meanwhile.
//  5 Macro on, TIMEOUT=16, no rdv -> 16 cycles later m0 gets 0xDEADBEEF, err pulse;
//    rdv injected 3 cycles later not forwarded.
//  6 Reset asserted in WAIT_RDV, rdv arrives after release -> no m_readdatavalid_o.

Source files
------------

// File: rtl/avl_uart_arb_pkg.sv
// Shared types and constants for the UART Avalon-MM arbiter.
// Optional read timeout is enabled by defining AVL_UART_ARB_TIMEOUT_EN.
package avl_uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDV = 2'd2
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avl_uart_rr_picker.sv
// Combinational round-robin pick: first requester strictly after last_grant_i,
// wrapping modulo NB_MASTERS.
module avl_uart_rr_picker
  import avl_uart_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  localparam int GW = grant_w(NB_MASTERS)
) (
  input  logic [NB_MASTERS-1:0] req_i,
  input  logic [GW-1:0]         last_grant_i,
  output logic [GW-1:0]         grant_o,
  output logic                  valid_o
);

  logic [GW-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = NB_MASTERS; i >= 1; i--) begin
      idx = GW'((int'(last_grant_i) + i) % NB_MASTERS);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avl_uart_arbiter.sv
// Round-robin arbiter sharing the UART Avalon-MM slave among NB_MASTERS masters.
// Define AVL_UART_ARB_TIMEOUT_EN to enable the WAIT_RDV read timeout.
module avl_uart_arbiter
  import avl_uart_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                         avl_clk_i,
  input  logic                         avl_reset_n_i,
  input  logic [NB_MASTERS-1:0][13:0]  m_address_i,
  input  logic [NB_MASTERS-1:0][3:0]   m_byteenable_i,
  input  logic [NB_MASTERS-1:0][31:0]  m_writedata_i,
  input  logic [NB_MASTERS-1:0]        m_write_i,
  input  logic [NB_MASTERS-1:0]        m_read_i,
  output logic [NB_MASTERS-1:0]        m_waitrequest_o,
  output logic [NB_MASTERS-1:0]        m_readdatavalid_o,
  output logic [31:0]                  m_readdata_o,
  output logic [13:0]                  s_address_o,
  output logic [3:0]                   s_byteenable_o,
  output logic [31:0]                  s_writedata_o,
  output logic                         s_write_o,
  output logic                         s_read_o,
  input  logic [31:0]                  s_readdata_i,
  input  logic                         s_waitrequest_i,
  input  logic                         s_readdatavalid_i,
  output logic                         err_timeout_o
);

  localparam int GW = grant_w(NB_MASTERS);

  arb_state_t    state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] pick_grant;
  logic          pick_valid;
  logic          timeout_hit;

  avl_uart_rr_picker #(.NB_MASTERS(NB_MASTERS)) u_picker (
    .req_i        (m_read_i | m_write_i),
    .last_grant_i (last_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

`ifdef AVL_UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  assign timeout_hit = (state_q == WAIT_RDV) && !s_readdatavalid_i && (tmo_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge avl_clk_i or negedge avl_reset_n_i) begin
    if (!avl_reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NB_MASTERS - 1);
`ifdef AVL_UART_ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_grant;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!s_waitrequest_i) begin
            last_q  <= grant_q;
            state_q <= m_read_i[grant_q] ? WAIT_RDV : IDLE;
`ifdef AVL_UART_ARB_TIMEOUT_EN
            tmo_q   <= TW'(TIMEOUT - 1);
`endif
          end
        end
        WAIT_RDV: begin
          if (s_readdatavalid_i || timeout_hit) state_q <= IDLE;
`ifdef AVL_UART_ARB_TIMEOUT_EN
          else tmo_q <= tmo_q - 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slave-side and handshake outputs are combinational so waitrequest/readdatavalid
  // reach the granted master in the same cycle the UART produces them.
  always_comb begin
    m_waitrequest_o   = '1;
    m_readdatavalid_o = '0;
    m_readdata_o      = '0;
    s_address_o       = '0;
    s_byteenable_o    = '0;
    s_writedata_o     = '0;
    s_write_o         = 1'b0;
    s_read_o          = 1'b0;
    case (state_q)
      ISSUE: begin
        s_address_o              = m_address_i[grant_q];
        s_byteenable_o           = m_byteenable_i[grant_q];
        s_writedata_o            = m_writedata_i[grant_q];
        s_read_o                 = m_read_i[grant_q];
        s_write_o                = m_write_i[grant_q] & ~m_read_i[grant_q];
        m_waitrequest_o[grant_q] = s_waitrequest_i;
      end
      WAIT_RDV: begin
        if (s_readdatavalid_i) begin
          m_readdatavalid_o[grant_q] = 1'b1;
          m_readdata_o               = s_readdata_i;
        end else if (timeout_hit) begin
          m_readdatavalid_o[grant_q] = 1'b1;
          m_readdata_o               = TIMEOUT_DATA;
        end
      end
      default: ;
    endcase
  end

  assign err_timeout_o = timeout_hit;

`ifndef SYNTHESIS
  a_rd_wr_both: assert property (@(posedge avl_clk_i) disable iff (!avl_reset_n_i)
    !(|(m_read_i & m_write_i)))
    else $warning("master drives read and write together; treated as read");

  a_req_held: assert property (@(posedge avl_clk_i) disable iff (!avl_reset_n_i)
    (state_q == ISSUE) |-> (m_read_i[grant_q] | m_write_i[grant_q]))
    else $error("granted master dropped its request while waitrequest was high");

  a_one_owner: assert property (@(posedge avl_clk_i) disable iff (!avl_reset_n_i)
    $onehot0(~m_waitrequest_o) && $onehot0(m_readdatavalid_o))
    else $error("more than one master sees waitrequest low or readdatavalid high");
`endif

endmodule
